// File: rtl/pulse_gen_pkg.sv
// Shared types and legal parameter values for the pulse generator.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam string MODE_ONESHOT = "ONESHOT";
  localparam string MODE_RETRIG  = "RETRIG";
  localparam string POL_HIGH     = "HIGH";
  localparam string POL_LOW      = "LOW";

endpackage

// File: rtl/pulse_gen_dcnt.sv
// Loadable down-counter that saturates at zero; zero_o marks the last cycle of a phase.
module pulse_gen_dcnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          dec_i,
  input  logic [CW-1:0] val_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_gen.sv
// Edge-triggered pulse generator (one-shot or retriggerable) with a post-pulse hold-off.
// All outputs are registered from the next state, giving one cycle of latency from the trigger edge.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int    CW      = 8,
  parameter string MODE    = "ONESHOT",
  parameter string OUT_POL = "HIGH"
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          trig,
  input  logic [CW-1:0] len,
  input  logic [CW-1:0] gap,
  output logic          out,
  output logic          busy,
  output logic          drop
);

  if ((CW < 2) || (CW > 16)) begin : g_bad_cw
    $error("pulse_gen: CW must be in 2..16");
  end
  if ((MODE != MODE_ONESHOT) && (MODE != MODE_RETRIG)) begin : g_bad_mode
    $error("pulse_gen: MODE must be ONESHOT or RETRIG");
  end
  if ((OUT_POL != POL_HIGH) && (OUT_POL != POL_LOW)) begin : g_bad_pol
    $error("pulse_gen: OUT_POL must be HIGH or LOW");
  end

  localparam bit IsRetrig = (MODE == MODE_RETRIG);
  localparam bit ActLow   = (OUT_POL == POL_LOW);

  state_e        state_q, state_d;
  logic          trig_q;
  logic          edge_w;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_val, len_m1;
  logic          out_q, out_d, busy_q, busy_d, drop_q, drop_d;

  assign edge_w = trig & ~trig_q;
  // Counter holds "cycles left after this one", so len==0 and len==1 both give one cycle.
  assign len_m1 = (len == '0) ? '0 : (len - CW'(1));

  pulse_gen_dcnt #(.CW(CW)) u_dcnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .val_i  (cnt_val),
    .zero_o (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      trig_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      trig_q  <= trig;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = len_m1;
    case (state_q)
      IDLE: begin
        if (edge_w) begin
          state_d  = ACTIVE;
          cnt_load = 1'b1;
        end
      end
      ACTIVE: begin
        if (edge_w && IsRetrig) begin
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          if (gap != '0) begin
            state_d  = HOLD;
            cnt_load = 1'b1;
            cnt_val  = gap - CW'(1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d  = (state_d == ACTIVE) ^ ActLow;
    busy_d = (state_d != IDLE);
    drop_d = edge_w && ((state_q == HOLD) || ((state_q == ACTIVE) && !IsRetrig));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= ActLow;
      busy_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      busy_q <= busy_d;
      drop_q <= drop_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign drop = drop_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: three instances (ONESHOT/HIGH, RETRIG/HIGH, ONESHOT/LOW) against a cycle-count model.
module tb_pulse_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       trig = 1'b1;
  logic [7:0] len = 8'd0;
  logic [7:0] gap = 8'd0;

  logic out_os, busy_os, drop_os;
  logic out_rt, busy_rt, drop_rt;
  logic out_lo, busy_lo, drop_lo;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pulse_gen #(.CW(8), .MODE("ONESHOT"), .OUT_POL("HIGH")) u_os (
    .clk(clk), .rst_n(rst_n), .trig(trig), .len(len), .gap(gap),
    .out(out_os), .busy(busy_os), .drop(drop_os));

  pulse_gen #(.CW(8), .MODE("RETRIG"), .OUT_POL("HIGH")) u_rt (
    .clk(clk), .rst_n(rst_n), .trig(trig), .len(len), .gap(gap),
    .out(out_rt), .busy(busy_rt), .drop(drop_rt));

  pulse_gen #(.CW(8), .MODE("ONESHOT"), .OUT_POL("LOW")) u_lo (
    .clk(clk), .rst_n(rst_n), .trig(trig), .len(len), .gap(gap),
    .out(out_lo), .busy(busy_lo), .drop(drop_lo));

  logic [8:0] obs_w;
  assign obs_w = {out_os, busy_os, drop_os, out_rt, busy_rt, drop_rt, out_lo, busy_lo, drop_lo};

  localparam logic [8:0] RESET_V = 9'b000_000_100;

  // Model: act = active cycles remaining including the visible one, hold = hold-off cycles remaining.
  int       act [3];
  int       hold[3];
  bit       prev;
  bit [8:0] exp_v;
  bit       is_rt [3] = '{1'b0, 1'b1, 1'b0};
  bit       is_low[3] = '{1'b0, 1'b0, 1'b1};

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      act[i]  = 0;
      hold[i] = 0;
    end
    prev  = 1'b1;
    exp_v = RESET_V;
  endtask

  task automatic model_step();
    bit e;
    bit d;
    int l;
    e    = trig && !prev;
    prev = trig;
    l    = (len == 8'd0) ? 1 : int'(len);
    for (int i = 0; i < 3; i++) begin
      d = 1'b0;
      if (act[i] > 0) begin
        if (e && is_rt[i]) begin
          act[i] = l;
        end else begin
          d = e;
          act[i] = act[i] - 1;
          if (act[i] == 0) hold[i] = int'(gap);
        end
      end else if (hold[i] > 0) begin
        d = e;
        hold[i] = hold[i] - 1;
      end else if (e) begin
        act[i] = l;
      end
      exp_v[8-3*i] = (act[i] > 0) ^ is_low[i];
      exp_v[7-3*i] = (act[i] > 0) || (hold[i] > 0);
      exp_v[6-3*i] = d;
    end
  endtask

  // Drive trig for one cycle, advance the model on the clock edge, settle outputs.
  task automatic tick(input bit t);
    trig = t;
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    trig  = 1'b1;
    len   = 8'd3;
    gap   = 8'd1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs_w !== RESET_V) $display("FAIL reset_state obs=%b exp=%b", obs_w, RESET_V);
    else n_pass++;
    for (int c = 0; c < 3; c++) tick(1'b1);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(1'b1);
      n_checks++;
      if (obs_w !== exp_v || out_os !== 1'b0) $display("FAIL trig_held_release c=%0d obs=%b exp=%b", c, obs_w, exp_v);
      else n_pass++;
    end
    tick(1'b0);
    tick(1'b1);
    n_checks++;
    if (obs_w !== exp_v || out_os !== 1'b1) $display("FAIL first_edge_after_reset obs=%b exp=%b", obs_w, exp_v);
    else n_pass++;
    for (int c = 0; c < 6; c++) begin
      tick(1'b0);
      n_checks++;
      if (obs_w !== exp_v) $display("FAIL post_reset_pulse c=%0d obs=%b exp=%b", c, obs_w, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_oneshot();
    bit [13:0] pat = 14'b1101_0001_0000_00;
    int hi = 0, bz = 0, dr = 0;
    len = 8'd5;
    gap = 8'd3;
    for (int c = 0; c < 8; c++) tick(1'b0);
    for (int c = 13; c >= 0; c--) begin
      tick(pat[c]);
      hi += int'(out_os);
      bz += int'(busy_os);
      dr += int'(drop_os);
      n_checks++;
      if (obs_w !== exp_v) $display("FAIL oneshot c=%0d obs=%b exp=%b", 13 - c, obs_w, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (hi !== 5 || bz !== 8 || dr !== 2)
      $display("FAIL oneshot_counts out=%0d busy=%0d drop=%0d want 5/8/2", hi, bz, dr);
    else n_pass++;
  endtask

  task automatic test_retrig();
    bit [8:0] pat = 9'b1010_0000_0;
    int hi = 0, dr = 0;
    len = 8'd4;
    gap = 8'd0;
    for (int c = 0; c < 8; c++) tick(1'b0);
    for (int c = 8; c >= 0; c--) begin
      tick(pat[c]);
      hi += int'(out_rt);
      dr += int'(drop_rt);
      n_checks++;
      if (obs_w !== exp_v) $display("FAIL retrig c=%0d obs=%b exp=%b", 8 - c, obs_w, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (hi !== 6 || dr !== 0) $display("FAIL retrig_counts out=%0d drop=%0d want 6/0", hi, dr);
    else n_pass++;
  endtask

  task automatic test_len0();
    bit [5:0] pat = 6'b1010_00;
    int hi = 0;
    len = 8'd0;
    gap = 8'd0;
    for (int c = 0; c < 8; c++) tick(1'b0);
    for (int c = 5; c >= 0; c--) begin
      tick(pat[c]);
      hi += int'(out_os);
      n_checks++;
      if (obs_w !== exp_v) $display("FAIL len0 c=%0d obs=%b exp=%b", 5 - c, obs_w, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (hi !== 2) $display("FAIL len0_count out=%0d want 2", hi);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      len = 8'($urandom_range(0, 6));
      gap = 8'($urandom_range(0, 3));
      tick(1'($urandom_range(0, 1)));
      n_checks++;
      if (obs_w !== exp_v) $display("FAIL random c=%0d len=%0d gap=%0d obs=%b exp=%b", c, len, gap, obs_w, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_pulse();
    len = 8'd200;
    gap = 8'd2;
    for (int c = 0; c < 8; c++) tick(1'b0);
    tick(1'b1);
    for (int c = 0; c < 49; c++) tick(1'b0);
    n_checks++;
    if (out_lo !== 1'b0 || busy_lo !== 1'b1 || obs_w !== exp_v)
      $display("FAIL long_pulse_active obs=%b exp=%b", obs_w, exp_v);
    else n_pass++;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs_w !== RESET_V) $display("FAIL async_reset_mid_pulse obs=%b exp=%b", obs_w, RESET_V);
    else n_pass++;
    tick(1'b0);
    tick(1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick(1'b0);
      n_checks++;
      if (obs_w !== exp_v || out_lo !== 1'b1) $display("FAIL no_resume c=%0d obs=%b exp=%b", c, obs_w, exp_v);
      else n_pass++;
    end
    len = 8'd3;
    tick(1'b1);
    for (int c = 0; c < 7; c++) begin
      tick(1'b0);
      n_checks++;
      if (obs_w !== exp_v) $display("FAIL new_pulse_after_reset c=%0d obs=%b exp=%b", c, obs_w, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_oneshot();
    test_retrig();
    test_len0();
    test_random();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
